uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a data source and the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running baud counter; tick marks the last clock of each bit period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, start/data/parity/stop serialization,
// new frames held off until the PLL reports lock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    uart_tx_if.slave   s_if,
    output logic       tx,
    output logic       busy
);
    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    if (CPB < 2) begin : g_bad_cpb
        $fatal(1, "uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx: DATA_BITS must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 accept;
    logic                 tick;

    assign s_if.tx_ready = (state_q == S_IDLE) && pll_locked;
    assign accept        = s_if.tx_valid && s_if.tx_ready;
    assign tx            = tx_q;
    assign busy          = busy_q;

    uart_baud_tick #(
        .CLKS_PER_BIT (CPB)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

    // Next-state, shift and bit-count logic; every bit state advances on the baud tick.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    shift_d   = s_if.tx_data;
                    parity_d  = (^s_if.tx_data) ^ (PARITY == PARITY_ODD);
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level follows the current state one clock later.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: three parameterisations at 4 clocks per bit
// (A: no parity/1 stop, B: odd parity/1 stop, C: no parity/2 stop).
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic pll_locked;
    logic tx_a, tx_b, tx_c;
    logic busy_a, busy_b, busy_c;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   sel      = 0;
    logic [7:0] exp_q[$];

    logic obs_tx, obs_busy, obs_ready;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) if_a ();
    uart_tx_if #(.DATA_BITS(8)) if_b ();
    uart_tx_if #(.DATA_BITS(8)) if_c ();

    uart_tx #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .s_if(if_a.slave), .tx(tx_a), .busy(busy_a));
    uart_tx #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .s_if(if_b.slave), .tx(tx_b), .busy(busy_b));
    uart_tx #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .s_if(if_c.slave), .tx(tx_c), .busy(busy_c));

    always_comb begin
        case (sel)
            0:       begin obs_tx = tx_a; obs_busy = busy_a; obs_ready = if_a.tx_ready; end
            1:       begin obs_tx = tx_b; obs_busy = busy_b; obs_ready = if_b.tx_ready; end
            default: begin obs_tx = tx_c; obs_busy = busy_c; obs_ready = if_c.tx_ready; end
        endcase
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<300000", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            0:       begin if_a.tx_valid = v; if_a.tx_data = d; end
            1:       begin if_b.tx_valid = v; if_b.tx_data = d; end
            default: begin if_c.tx_valid = v; if_c.tx_data = d; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present one byte for a single accepting edge and record it on the scoreboard.
    task automatic send(input int s, input logic [7:0] d);
        n_assert++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_send dut=%0d got=%b expected=1", s, obs_ready);
        end
        drive(s, 1'b1, d);
        exp_q.push_back(d);
        @(negedge clk);
        drive(s, 1'b0, d);
    endtask

    // Wait for a start bit, then check every clock of the frame against the expected byte.
    task automatic rx_frame(input int s, output logic [7:0] data_seen, output logic par_seen,
                            output int waited, output int bcnt);
        logic [7:0] d;
        logic       lv[0:11];
        int         nb;
        int         bad;
        bit         found;
        bit         has_par;
        int         n_stop;
        d         = 8'h00;
        data_seen = 8'h00;
        par_seen  = 1'b1;
        waited    = 0;
        bcnt      = 0;
        has_par   = (s == 1);
        n_stop    = (s == 2) ? 2 : 1;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty dut=%0d got=0 entries expected>=1", s);
        end else begin
            d = exp_q.pop_front();
        end
        nb = 0;
        lv[nb] = 1'b0; nb = nb + 1;
        for (int i = 0; i < 8; i++) begin lv[nb] = d[i]; nb = nb + 1; end
        if (has_par) begin lv[nb] = ~(^d); nb = nb + 1; end
        for (int i = 0; i < n_stop; i++) begin lv[nb] = 1'b1; nb = nb + 1; end
        found = 1'b0;
        for (int w = 0; w < 300 && !found; w++) begin
            @(negedge clk);
            if (obs_tx === 1'b0) found = 1'b1;
            else waited++;
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL start_timeout dut=%0d got=no start bit expected=start within 300 cycles", s);
        end else begin
            bad = 0;
            for (int c = 0; c < nb * 4; c++) begin
                if (c > 0) @(negedge clk);
                if (obs_tx !== lv[c / 4]) bad++;
                if (obs_busy === 1'b1) bcnt++;
                if ((c % 4) == 2) begin
                    if (c / 4 >= 1 && c / 4 <= 8) data_seen[c / 4 - 1] = obs_tx;
                    if (has_par && c / 4 == 9) par_seen = obs_tx;
                end
            end
            n_assert++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL frame_shape dut=%0d byte=%h got=%0d wrong cycles expected=0", s, d, bad);
            end
            n_assert++;
            if (data_seen !== d) begin
                n_fail++;
                $display("FAIL frame_data dut=%0d got=%h expected=%h", s, data_seen, d);
            end
        end
    endtask

    task automatic test_reset();
        logic [2:0] txs, bsy, rdy;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        txs = {tx_c, tx_b, tx_a};
        bsy = {busy_c, busy_b, busy_a};
        rdy = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
        n_assert++;
        if (txs !== 3'b111) begin n_fail++; $display("FAIL reset_tx got=%b expected=111", txs); end
        n_assert++;
        if (bsy !== 3'b000) begin n_fail++; $display("FAIL reset_busy got=%b expected=000", bsy); end
        n_assert++;
        if (rdy !== 3'b000) begin n_fail++; $display("FAIL reset_ready_unlocked got=%b expected=000", rdy); end
        rst_n = 1'b1;
        @(negedge clk);
        pll_locked = 1'b1;
        #1;
        rdy = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
        n_assert++;
        if (rdy !== 3'b111) begin n_fail++; $display("FAIL ready_locked got=%b expected=111", rdy); end
        @(negedge clk);
    endtask

    task automatic test_smoke();
        logic [7:0] ds; logic ps; int waited, bcnt;
        sel = 0;
        send(0, 8'hA5);
        n_assert++;
        if (obs_tx !== 1'b1 || obs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_edge got tx=%b busy=%b expected tx=1 busy=1", obs_tx, obs_busy);
        end
        rx_frame(0, ds, ps, waited, bcnt);
        n_assert++;
        if (waited != 0) begin n_fail++; $display("FAIL start_latency got=%0d extra cycles expected=0", waited); end
        n_assert++;
        if (bcnt + 1 != 40) begin n_fail++; $display("FAIL busy_cycles got=%0d expected=40", bcnt + 1); end
        @(negedge clk);
        n_assert++;
        if (obs_tx !== 1'b1 || obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_frame got tx=%b busy=%b expected tx=1 busy=0", obs_tx, obs_busy);
        end
    endtask

    task automatic test_startup_gating();
        logic [7:0] ds; logic ps; int waited, bcnt, bad;
        sel = 0;
        pll_locked = 1'b0;
        do_reset();
        drive(0, 1'b1, 8'h3C);
        exp_q.push_back(8'h3C);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (obs_ready !== 1'b0 || obs_tx !== 1'b1) bad++;
        end
        n_assert++;
        if (bad != 0) begin n_fail++; $display("FAIL gated_hold got=%0d bad cycles expected=0", bad); end
        pll_locked = 1'b1;
        #1;
        n_assert++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL ready_on_lock got=%b expected=1", obs_ready); end
        @(negedge clk);
        drive(0, 1'b0, 8'h3C);
        rx_frame(0, ds, ps, waited, bcnt);
        n_assert++;
        if (waited != 0) begin n_fail++; $display("FAIL gated_latency got=%0d extra cycles expected=0", waited); end
        @(negedge clk);
    endtask

    task automatic test_parity();
        logic [7:0] ds; logic ps; int waited, bcnt;
        sel = 1;
        send(1, 8'h07);
        rx_frame(1, ds, ps, waited, bcnt);
        n_assert++;
        if (ps !== 1'b0) begin n_fail++; $display("FAIL parity_07 got=%b expected=0", ps); end
        n_assert++;
        if (bcnt + 1 != 44) begin n_fail++; $display("FAIL parity_frame_len got=%0d expected=44", bcnt + 1); end
        @(negedge clk);
        send(1, 8'h03);
        rx_frame(1, ds, ps, waited, bcnt);
        n_assert++;
        if (ps !== 1'b1) begin n_fail++; $display("FAIL parity_03 got=%b expected=1", ps); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ds; logic ps; int waited, bcnt, lows;
        sel = 2;
        n_assert++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b expected=1", obs_ready); end
        drive(2, 1'b1, 8'h00);
        exp_q.push_back(8'h00);
        @(negedge clk);
        drive(2, 1'b1, 8'hFF);
        exp_q.push_back(8'hFF);
        fork
            begin
                rx_frame(2, ds, ps, waited, bcnt);
                n_assert++;
                if (ds !== 8'h00) begin n_fail++; $display("FAIL b2b_first_zeros got=%h expected=00", ds); end
                rx_frame(2, ds, ps, waited, bcnt);
                n_assert++;
                if (waited != 1) begin n_fail++; $display("FAIL b2b_gap got=%0d idle cycles expected=1", waited); end
            end
            begin
                int k;
                k = 0;
                while (obs_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
                while (obs_ready !== 1'b0 && k < 400) begin @(negedge clk); k++; end
                drive(2, 1'b0, 8'hFF);
                n_assert++;
                if (k >= 400) begin n_fail++; $display("FAIL b2b_second_accept got=timeout expected=accept"); end
            end
        join
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (obs_tx !== 1'b1) lows++;
        end
        n_assert++;
        if (lows != 0) begin n_fail++; $display("FAIL b2b_no_extra got=%0d low cycles expected=0", lows); end
    endtask

    task automatic test_pll_drop();
        logic [7:0] ds; logic ps; int waited, bcnt, bad;
        sel = 0;
        send(0, 8'h96);
        fork
            rx_frame(0, ds, ps, waited, bcnt);
            begin
                for (int w = 0; w < 300; w++) begin
                    @(negedge clk);
                    if (obs_tx === 1'b0) break;
                end
                repeat (17) @(negedge clk);
                pll_locked = 1'b0;
            end
        join
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (obs_ready !== 1'b0 || obs_tx !== 1'b1 || obs_busy !== 1'b0) bad++;
        end
        n_assert++;
        if (bad != 0) begin n_fail++; $display("FAIL pll_drop_hold got=%0d bad cycles expected=0", bad); end
        pll_locked = 1'b1;
        #1;
        n_assert++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL pll_return_ready got=%b expected=1", obs_ready); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] dropped;
        int lows;
        sel = 0;
        send(0, 8'h00);
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (obs_tx === 1'b0) break;
        end
        repeat (25) @(negedge clk);
        n_assert++;
        if (obs_tx !== 1'b0) begin n_fail++; $display("FAIL pre_reset_bit5 got=%b expected=0", obs_tx); end
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (obs_tx !== 1'b1 || obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got tx=%b busy=%b expected tx=1 busy=0", obs_tx, obs_busy);
        end
        if (exp_q.size() != 0) dropped = exp_q.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (obs_tx !== 1'b1 || obs_busy !== 1'b0) lows++;
        end
        n_assert++;
        if (lows != 0) begin n_fail++; $display("FAIL no_residual got=%0d bad cycles expected=0", lows); end
        n_assert++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b expected=1", obs_ready); end
    endtask

    task automatic test_data_stability();
        logic [7:0] ds; logic ps; int waited, bcnt;
        sel = 1;
        send(1, 8'h5A);
        fork
            rx_frame(1, ds, ps, waited, bcnt);
            begin
                for (int i = 0; i < 50; i++) begin
                    drive(1, 1'b0, 8'($urandom));
                    @(negedge clk);
                end
            end
        join
        n_assert++;
        if (ps !== 1'b1) begin n_fail++; $display("FAIL stability_parity got=%b expected=1", ps); end
        n_assert++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size()); end
    endtask

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        test_reset();
        test_smoke();
        test_startup_gating();
        test_parity();
        test_back_to_back();
        test_pll_drop();
        test_reset_mid_frame();
        test_data_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
